bf_core: RTL and testbench

Parametrised multi-cycle accumulator core: the next generation of the 8-bit fetch/decode/execute controller. It adds configurable data width, address width and register count, a conditional branch, add-immediate, a run/idle control and a debug register read-out. It sits at the top of the processor and talks directly to a single-port synchronous RAM holding both program and data.

---
 rtl/bf_pkg.sv | 35 +++
 rtl/bf_if.sv | 13 +
 rtl/bf_regfile.sv | 29 ++
 rtl/bf_core.sv | 101 ++++++++++
 tb/tb_bf_core.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the bf accumulator core: opcodes, FSM encoding and
// instruction field extraction usable at any data/register-select width.
package bf_pkg;

    localparam logic [1:0] OP_BRZ  = 2'b00;
    localparam logic [1:0] OP_LD   = 2'b01;
    localparam logic [1:0] OP_ST   = 2'b10;
    localparam logic [1:0] OP_ADDI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD
    } state_t;

    // Helpers operate on a zero-extended instruction so one set covers every DW.
    localparam int MAXW = 64;

    function automatic logic [1:0] f_op(input logic [MAXW-1:0] inst, input int dw);
        return 2'(inst >> (dw - 2));
    endfunction

    function automatic logic [MAXW-1:0] f_rs(input logic [MAXW-1:0] inst, input int dw,
                                             input int rsw);
        return (inst >> (dw - 2 - rsw)) & ((MAXW'(1) << rsw) - MAXW'(1));
    endfunction

    function automatic logic [MAXW-1:0] f_imm(input logic [MAXW-1:0] inst, input int dw,
                                              input int rsw);
        return inst & ((MAXW'(1) << (dw - 2 - rsw)) - MAXW'(1));
    endfunction

endpackage

// File: rtl/bf_if.sv
// Single-port synchronous RAM bus between the core (master) and memory (slave).
interface bf_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] addr;
    logic [DW-1:0] data_out;
    logic [DW-1:0] data_in;
    logic          we;

    modport master (output addr, output data_out, output we, input data_in);
    modport slave  (input addr, input data_out, input we, output data_in);
endinterface

// File: rtl/bf_regfile.sv
// Accumulator register file: one write port, an operand read port and a
// debug read port, all reads combinational.
module bf_regfile #(
    parameter int  DW    = 8,
    parameter int  NREGS = 2,
    localparam int RSW   = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wen,
    input  logic [RSW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RSW-1:0] raddr,
    output logic [DW-1:0]  rdata,
    input  logic [RSW-1:0] dbg_sel,
    output logic [DW-1:0]  dbg_data
);
    logic [NREGS-1:0][DW-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (wen)
            regs[waddr] <= wdata;
    end

    assign rdata    = regs[raddr];
    assign dbg_data = regs[dbg_sel];
endmodule

// File: rtl/bf_core.sv
// Multi-cycle fetch/decode/execute accumulator core driving a shared
// program/data RAM; BRZ, LD, ST and ADDI on a parametrised register file.
module bf_core
    import bf_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            AW       = 8,
    parameter int            NREGS    = 2,
    parameter logic [AW-1:0] RESET_PC = '0,
    localparam int           RSW      = $clog2(NREGS),
    localparam int           IW       = DW - 2 - RSW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    bf_if.master           bus,
    output logic [AW-1:0]  pc,
    output logic           busy,
    output logic           retire,
    input  logic [RSW-1:0] dbg_sel,
    output logic [DW-1:0]  dbg_reg
);
    state_t         state;
    logic [DW-1:0]  inst;
    logic [1:0]     op;
    logic [RSW-1:0] rs;
    logic [IW-1:0]  imm;
    logic [AW-1:0]  ea;
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  sext_imm;
    logic           done;
    logic           taken;
    logic           mem_op;
    logic           wr;
    logic           reg_wen;
    logic [DW-1:0]  reg_wdata;

    assign op       = f_op(MAXW'(inst), DW);
    assign rs       = RSW'(f_rs(MAXW'(inst), DW, RSW));
    assign imm      = IW'(f_imm(MAXW'(inst), DW, RSW));
    assign ea       = AW'(imm);
    assign sext_imm = {{(DW-IW){imm[IW-1]}}, imm};

    assign done   = (state == S_EXEC && op != OP_LD) || state == S_MEMRD;
    assign taken  = op == OP_BRZ && rs_val == '0;
    assign mem_op = op == OP_LD || op == OP_ST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            case (state)
                S_IDLE:   if (run) state <= S_FETCH;
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    inst  <= bus.data_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_LD) begin
                        state <= S_MEMRD;
                    end else begin
                        pc    <= taken ? ea : pc + AW'(1);
                        state <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_MEMRD: begin
                    pc    <= pc + AW'(1);
                    state <= run ? S_FETCH : S_IDLE;
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    // LD data arrives in MEMRD; ADDI writes back directly from EXEC.
    assign reg_wen   = (state == S_EXEC && op == OP_ADDI) || state == S_MEMRD;
    assign reg_wdata = (state == S_MEMRD) ? bus.data_in : rs_val + sext_imm;

    bf_regfile #(.DW(DW), .NREGS(NREGS)) u_regs (
        .clk      (clk),
        .rst      (rst),
        .wen      (reg_wen),
        .waddr    (rs),
        .wdata    (reg_wdata),
        .raddr    (rs),
        .rdata    (rs_val),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_reg)
    );

    // The rst term keeps a reset landing on ST EXEC from corrupting memory.
    assign wr           = state == S_EXEC && op == OP_ST && !rst;
    assign bus.we       = wr;
    assign bus.data_out = wr ? rs_val : '0;
    assign bus.addr     = ((state == S_EXEC && mem_op) || state == S_MEMRD) ? ea : pc;
    assign busy         = state != S_IDLE;
    assign retire       = done;
endmodule

// File: tb/tb_bf_core.sv
// Directed bench for bf_core: 8-bit core, an 8-bit core with RESET_PC=0xFF,
// and a 16-bit/12-bit/4-register variant, each with its own RAM model.
module tb_bf_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // 8-bit core, RESET_PC = 0
    logic       rst8, run8, busy8, ret8;
    logic [0:0] sel8;
    logic [7:0] pc8, dbg8;
    logic [7:0] mem8 [256];
    int         nwe8 = 0, nret8 = 0;
    bf_if #(.DW(8), .AW(8)) bus8 ();
    bf_core #(.DW(8), .AW(8), .NREGS(2), .RESET_PC(8'h00)) u8 (
        .clk(clk), .rst(rst8), .run(run8), .bus(bus8), .pc(pc8), .busy(busy8),
        .retire(ret8), .dbg_sel(sel8), .dbg_reg(dbg8));

    always @(posedge clk) begin
        bus8.data_in <= mem8[bus8.addr];
        if (bus8.we) begin
            mem8[bus8.addr] = bus8.data_out;
            nwe8++;
        end
        if (ret8) nret8++;
    end

    // 8-bit core, RESET_PC = 0xFF
    logic       rstw, runw, busyw, retw;
    logic [0:0] selw;
    logic [7:0] pcw, dbgw;
    logic [7:0] memw [256];
    bf_if #(.DW(8), .AW(8)) busw ();
    bf_core #(.DW(8), .AW(8), .NREGS(2), .RESET_PC(8'hFF)) uw (
        .clk(clk), .rst(rstw), .run(runw), .bus(busw), .pc(pcw), .busy(busyw),
        .retire(retw), .dbg_sel(selw), .dbg_reg(dbgw));

    always @(posedge clk) begin
        busw.data_in <= memw[busw.addr];
        if (busw.we) memw[busw.addr] = busw.data_out;
    end

    // 16-bit data, 12-bit address, 4 registers
    logic        rst16, run16, busy16, ret16;
    logic [1:0]  sel16;
    logic [11:0] pc16;
    logic [15:0] dbg16;
    logic [15:0] mem16 [4096];
    bf_if #(.DW(16), .AW(12)) bus16 ();
    bf_core #(.DW(16), .AW(12), .NREGS(4), .RESET_PC(12'h000)) u16 (
        .clk(clk), .rst(rst16), .run(run16), .bus(bus16), .pc(pc16), .busy(busy16),
        .retire(ret16), .dbg_sel(sel16), .dbg_reg(dbg16));

    always @(posedge clk) begin
        bus16.data_in <= mem16[bus16.addr];
        if (bus16.we) mem16[bus16.addr] = bus16.data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst8 = 1'b1; run8 = 1'b1; sel8 = 1'b0;
        rstw = 1'b1; runw = 1'b0; selw = 1'b0;
        rst16 = 1'b1; run16 = 1'b0; sel16 = 2'd0;
        for (int i = 0; i < 256; i++) begin
            mem8[i] = 8'h00;
            memw[i] = 8'h00;
        end
        for (int i = 0; i < 4096; i++) mem16[i] = 16'h0000;
        // ADDI R0,3 ; ST R0,0x10 ; LD R1,0x10 ; BRZ R1,5 ; ST R0,0x11 ; ST R0,0x12
        mem8[0] = 8'hC3; mem8[1] = 8'h90; mem8[2] = 8'h70;
        mem8[3] = 8'h25; mem8[4] = 8'h91; mem8[5] = 8'h92;
        memw[8'hFF] = 8'hC1;
        // ADDI R3,-2 ; ST R3,0xABC ; LD R2,0xABC
        mem16[0] = 16'hFFFE; mem16[1] = 16'hBABC; mem16[2] = 16'h6ABC;

        // Reset held two cycles with run high
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_addr", bus8.addr, 8'h00);
            chk("rst_we", bus8.we, 1'b0);
            chk("rst_busy", busy8, 1'b0);
            chk("rst_dbg", dbg8, 8'h00);
            chk("rst_dout", bus8.data_out, 8'h00);
            chk("rst_retire", ret8, 1'b0);
        end
        rst8 = 1'b0;
        #1;
        chk("idle_busy", busy8, 1'b0);
        tick();
        chk("fetch0_addr", bus8.addr, 8'h00);
        chk("fetch0_busy", busy8, 1'b1);

        // ADDI R0,3
        tick();
        tick();
        chk("addi_retire", ret8, 1'b1);
        chk("addi_we", bus8.we, 1'b0);
        tick();
        chk("fetch1_addr", bus8.addr, 8'h01);
        chk("addi_r0", dbg8, 8'h03);

        // ST R0,0x10
        tick();
        tick();
        chk("st_we", bus8.we, 1'b1);
        chk("st_addr", bus8.addr, 8'h10);
        chk("st_dout", bus8.data_out, 8'h03);
        chk("st_retire", ret8, 1'b1);
        tick();
        chk("fetch2_addr", bus8.addr, 8'h02);
        chk("st_mem", mem8[8'h10], 8'h03);
        chk("fetch2_we", bus8.we, 1'b0);

        // LD R1,0x10
        tick();
        tick();
        chk("ld_exec_addr", bus8.addr, 8'h10);
        chk("ld_exec_retire", ret8, 1'b0);
        tick();
        chk("ld_memrd_addr", bus8.addr, 8'h10);
        chk("ld_memrd_retire", ret8, 1'b1);
        tick();
        chk("fetch3_addr", bus8.addr, 8'h03);
        sel8 = 1'b1;
        #1;
        chk("ld_r1", dbg8, 8'h03);
        sel8 = 1'b0;
        #1;
        chk("r0_kept", dbg8, 8'h03);
        chk("we_count", nwe8, 1);
        chk("retire_count", nret8, 3);

        // BRZ R1,5 with R1=3: not taken
        tick();
        tick();
        chk("brz_nt_retire", ret8, 1'b1);
        tick();
        chk("brz_nt_addr", bus8.addr, 8'h04);

        // ST R0,0x11 with run dropped during DECODE
        tick();
        run8 = 1'b0;
        tick();
        chk("strun_we", bus8.we, 1'b1);
        chk("strun_addr", bus8.addr, 8'h11);
        tick();
        chk("strun_idle_busy", busy8, 1'b0);
        chk("strun_idle_addr", bus8.addr, 8'h05);
        tick();
        chk("strun_hold_busy", busy8, 1'b0);
        chk("strun_hold_pc", pc8, 8'h05);
        chk("strun_mem", mem8[8'h11], 8'h03);

        // ST R0,0x12 aborted by reset in EXEC
        run8 = 1'b1;
        tick();
        chk("fetch5_addr", bus8.addr, 8'h05);
        tick();
        tick();
        rst8 = 1'b1;
        #1;
        chk("strst_we", bus8.we, 1'b0);
        chk("strst_dout", bus8.data_out, 8'h00);
        tick();
        chk("strst_mem", mem8[8'h12], 8'h00);
        chk("strst_busy", busy8, 1'b0);
        chk("strst_addr", bus8.addr, 8'h00);
        chk("strst_r0", dbg8, 8'h00);

        // BRZ R1,5 from reset: taken
        mem8[0] = 8'h25;
        tick();
        rst8 = 1'b0;
        tick();
        tick();
        tick();
        chk("brz_t_retire", ret8, 1'b1);
        tick();
        chk("brz_t_addr", bus8.addr, 8'h05);

        // ADDI R0,-1 from reset: 0 wraps to 0xFF
        rst8 = 1'b1;
        mem8[0] = 8'hDF;
        tick();
        rst8 = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("addi_neg_r0", dbg8, 8'hFF);
        chk("addi_neg_addr", bus8.addr, 8'h01);
        rst8 = 1'b1;

        // RESET_PC = 0xFF: ADDI R0,1 then PC wraps to 0
        chk("wrap_rst_addr", busw.addr, 8'hFF);
        rstw = 1'b0;
        runw = 1'b1;
        tick();
        chk("wrap_fetch_addr", busw.addr, 8'hFF);
        tick();
        tick();
        tick();
        chk("wrap_r0", dbgw, 8'h01);
        chk("wrap_addr", busw.addr, 8'h00);
        rstw = 1'b1;

        // Wide variant
        rst16 = 1'b0;
        run16 = 1'b1;
        repeat (6) tick();
        chk("w16_st_we", bus16.we, 1'b1);
        chk("w16_st_addr", bus16.addr, 12'hABC);
        chk("w16_st_dout", bus16.data_out, 16'hFFFE);
        repeat (5) tick();
        chk("w16_fetch3_addr", bus16.addr, 12'h003);
        chk("w16_mem", mem16[12'hABC], 16'hFFFE);
        sel16 = 2'd3;
        #1;
        chk("w16_r3", dbg16, 16'hFFFE);
        sel16 = 2'd2;
        #1;
        chk("w16_r2", dbg16, 16'hFFFE);
        rst16 = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
